// File: rtl/mips_defs.sv
`default_nettype none
// ============================================================================
// Module      : mips_defs (package)
// Description : Shared definitions for the single-cycle MIPS datapath:
//               register-address type, well-known register numbers and
//               register-file sizing defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_defs;

    // Register-file sizing defaults
    localparam int NUM_REGS_DEF = 32;
    localparam int DATA_W_DEF   = 32;

    // Architectural register number; shared with the write-register select
    // mux and the control unit.
    typedef logic [4:0] reg_addr_t;

    // $zero is hardwired, $ra is the jal link target
    localparam reg_addr_t REG_ZERO = 5'd0;
    localparam reg_addr_t REG_RA   = 5'd31;

endpackage : mips_defs
`default_nettype wire

// File: rtl/grf_read_port.sv
`default_nettype none
// ============================================================================
// Module      : grf_read_port
// Description : One combinational register-file read port. Forces $0 to
//               zero and optionally forwards the data being written this
//               cycle when the addresses match (write-through).
// Revision    : 1.0 - initial release
// ============================================================================
module grf_read_port
    import mips_defs::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int BYPASS   = 1
) (
    input  reg_addr_t                          i_addr,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]    i_regs,
    input  logic                               i_we,
    input  reg_addr_t                          i_a3,
    input  logic [DATA_W-1:0]                  i_wd,
    output logic [DATA_W-1:0]                  o_rd
);

    // Bypass only matters when enabled at elaboration time
    localparam logic c_bypass_en = (BYPASS != 0);

    logic w_fwd;

    // Forward write data when the same register is being written right now
    assign w_fwd = c_bypass_en && i_we && (i_a3 == i_addr);

    // $0 wins over forwarding; otherwise forwarded data or stored value
    always_comb begin
        o_rd = '0;
        if (i_addr != REG_ZERO) begin
            if (w_fwd) begin
                o_rd = i_wd;
            end else begin
                o_rd = i_regs[i_addr];
            end
        end
    end

endmodule : grf_read_port
`default_nettype wire

// File: rtl/grf.sv
`default_nettype none
// ============================================================================
// Module      : grf
// Description : General register file for the single-cycle MIPS datapath.
//               Two asynchronous read ports, one synchronous write port and
//               a registered trace of the last committed write.
// Revision    : 1.0 - initial release
// ============================================================================
module grf
    import mips_defs::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              WE,
    input  reg_addr_t         A1,
    input  reg_addr_t         A2,
    input  reg_addr_t         A3,
    input  logic [DATA_W-1:0] WD,
    input  logic [31:0]       PC,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic              trace_valid,
    output logic [31:0]       trace_pc,
    output reg_addr_t         trace_addr,
    output logic [DATA_W-1:0] trace_data,
    output logic [31:0]       write_count
);

    // Architectural register storage; entry 0 is never written
    logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;

    // A write only commits to a real register outside reset
    logic w_commit;
    assign w_commit = WE && (A3 != REG_ZERO) && !reset;

    // Register update and write-trace capture; reset overrides any write
    always_ff @(posedge clk) begin
        if (reset) begin
            r_regs      <= '0;
            trace_valid <= 1'b0;
            trace_pc    <= '0;
            trace_addr  <= REG_ZERO;
            trace_data  <= '0;
            write_count <= '0;
        end else begin
            trace_valid <= 1'b0;
            if (w_commit) begin
                r_regs[A3]  <= WD;
                trace_valid <= 1'b1;
                trace_pc    <= PC;
                trace_addr  <= A3;
                trace_data  <= WD;
                write_count <= write_count + 32'd1;
            end
        end
    end

    grf_read_port #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .BYPASS   (BYPASS)
    ) u_rd1 (
        .i_addr (A1),
        .i_regs (r_regs),
        .i_we   (WE),
        .i_a3   (A3),
        .i_wd   (WD),
        .o_rd   (RD1)
    );

    grf_read_port #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .BYPASS   (BYPASS)
    ) u_rd2 (
        .i_addr (A2),
        .i_regs (r_regs),
        .i_we   (WE),
        .i_a3   (A3),
        .i_wd   (WD),
        .o_rd   (RD2)
    );

endmodule : grf
`default_nettype wire

// File: tb/tb_grf.sv
`default_nettype none
// ============================================================================
// Module      : tb_grf
// Description : Directed self-checking bench for grf. Two instances share
//               all inputs: one with write-through reads, one without.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_grf;
    import mips_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        WE;
    reg_addr_t   A1, A2, A3;
    logic [31:0] WD, PC;

    logic [31:0] RD1, RD2, tpc, tdata, wcnt;
    logic        tvalid;
    reg_addr_t   taddr;

    logic [31:0] nb_RD1, nb_RD2, nb_tpc, nb_tdata, nb_wcnt;
    logic        nb_tvalid;
    reg_addr_t   nb_taddr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    grf #(.NUM_REGS(32), .DATA_W(32), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .WE(WE), .A1(A1), .A2(A2), .A3(A3),
        .WD(WD), .PC(PC), .RD1(RD1), .RD2(RD2), .trace_valid(tvalid),
        .trace_pc(tpc), .trace_addr(taddr), .trace_data(tdata),
        .write_count(wcnt)
    );

    grf #(.NUM_REGS(32), .DATA_W(32), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .WE(WE), .A1(A1), .A2(A2), .A3(A3),
        .WD(WD), .PC(PC), .RD1(nb_RD1), .RD2(nb_RD2), .trace_valid(nb_tvalid),
        .trace_pc(nb_tpc), .trace_addr(nb_taddr), .trace_data(nb_tdata),
        .write_count(nb_wcnt)
    );

    // Advance one rising edge; inputs change and outputs are sampled 1ns later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; WE = 1'b0; A1 = 5'd0; A2 = 5'd0; A3 = 5'd0;
        WD = 32'h0; PC = 32'h0;
        step();
        reset = 1'b0; A1 = 5'd5; A2 = REG_RA;
        #1;
        total++; if (RD1 !== 32'h0) begin bad++; $display("FAIL reset_rd1 got %h want %h", RD1, 32'h0); end
        total++; if (RD2 !== 32'h0) begin bad++; $display("FAIL reset_rd2 got %h want %h", RD2, 32'h0); end
        total++; if (wcnt !== 32'h0) begin bad++; $display("FAIL reset_wcnt got %h want %h", wcnt, 32'h0); end
        total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got %b want 0", tvalid); end
        total++; if (nb_wcnt !== 32'h0) begin bad++; $display("FAIL reset_nb_wcnt got %h want %h", nb_wcnt, 32'h0); end
    endtask

    task automatic test_basic_write();
        WE = 1'b1; A3 = 5'd8; WD = 32'h12345678; PC = 32'h3000;
        step();
        WE = 1'b0; A1 = 5'd8; WD = 32'h0; PC = 32'h3004;
        #1;
        total++; if (RD1 !== 32'h12345678) begin bad++; $display("FAIL basic_rd1 got %h want %h", RD1, 32'h12345678); end
        total++; if (tvalid !== 1'b1) begin bad++; $display("FAIL basic_tvalid got %b want 1", tvalid); end
        total++; if (tpc !== 32'h3000) begin bad++; $display("FAIL basic_tpc got %h want %h", tpc, 32'h3000); end
        total++; if (taddr !== 5'd8) begin bad++; $display("FAIL basic_taddr got %0d want 8", taddr); end
        total++; if (tdata !== 32'h12345678) begin bad++; $display("FAIL basic_tdata got %h want %h", tdata, 32'h12345678); end
        total++; if (wcnt !== 32'd1) begin bad++; $display("FAIL basic_wcnt got %0d want 1", wcnt); end
        step();
        total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL basic_tvalid_drop got %b want 0", tvalid); end
        total++; if (tpc !== 32'h3000) begin bad++; $display("FAIL basic_tpc_hold got %h want %h", tpc, 32'h3000); end
        total++; if (taddr !== 5'd8) begin bad++; $display("FAIL basic_taddr_hold got %0d want 8", taddr); end
        total++; if (wcnt !== 32'd1) begin bad++; $display("FAIL basic_wcnt_hold got %0d want 1", wcnt); end
    endtask

    task automatic test_zero_reg();
        WE = 1'b1; A3 = REG_ZERO; WD = 32'hFFFFFFFF; A1 = REG_ZERO; A2 = REG_ZERO;
        #1;
        total++; if (RD1 !== 32'h0) begin bad++; $display("FAIL zero_bypass_rd1 got %h want %h", RD1, 32'h0); end
        total++; if (RD2 !== 32'h0) begin bad++; $display("FAIL zero_bypass_rd2 got %h want %h", RD2, 32'h0); end
        step();
        WE = 1'b0;
        #1;
        total++; if (RD1 !== 32'h0) begin bad++; $display("FAIL zero_rd1 got %h want %h", RD1, 32'h0); end
        total++; if (nb_RD1 !== 32'h0) begin bad++; $display("FAIL zero_nb_rd1 got %h want %h", nb_RD1, 32'h0); end
        total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL zero_tvalid got %b want 0", tvalid); end
        total++; if (wcnt !== 32'd1) begin bad++; $display("FAIL zero_wcnt got %0d want 1", wcnt); end
    endtask

    task automatic test_bypass();
        // reg[9] = 1 first (write #2)
        WE = 1'b1; A3 = 5'd9; WD = 32'h1; PC = 32'h3008;
        step();
        // write #3: same address on all three ports
        A1 = 5'd9; A2 = 5'd9; A3 = 5'd9; WD = 32'hDEADBEEF; PC = 32'h300C;
        #1;
        total++; if (RD1 !== 32'hDEADBEEF) begin bad++; $display("FAIL bypass_rd1 got %h want %h", RD1, 32'hDEADBEEF); end
        total++; if (RD2 !== 32'hDEADBEEF) begin bad++; $display("FAIL bypass_rd2 got %h want %h", RD2, 32'hDEADBEEF); end
        total++; if (nb_RD1 !== 32'h1) begin bad++; $display("FAIL nobypass_rd1_pre got %h want %h", nb_RD1, 32'h1); end
        total++; if (nb_RD2 !== 32'h1) begin bad++; $display("FAIL nobypass_rd2_pre got %h want %h", nb_RD2, 32'h1); end
        // forwarding must not leak to a different address
        A2 = 5'd8;
        #1;
        total++; if (RD2 !== 32'h12345678) begin bad++; $display("FAIL bypass_other_rd2 got %h want %h", RD2, 32'h12345678); end
        step();
        WE = 1'b0; A2 = 5'd9;
        #1;
        total++; if (nb_RD1 !== 32'hDEADBEEF) begin bad++; $display("FAIL nobypass_rd1_post got %h want %h", nb_RD1, 32'hDEADBEEF); end
        total++; if (nb_RD2 !== 32'hDEADBEEF) begin bad++; $display("FAIL nobypass_rd2_post got %h want %h", nb_RD2, 32'hDEADBEEF); end
        total++; if (wcnt !== 32'd3) begin bad++; $display("FAIL bypass_wcnt got %0d want 3", wcnt); end
    endtask

    task automatic test_reset_priority();
        WE = 1'b1; A3 = REG_RA; WD = 32'h0000ABCD; PC = 32'h3010;
        step();
        WE = 1'b0; A1 = REG_RA;
        #1;
        total++; if (RD1 !== 32'h0000ABCD) begin bad++; $display("FAIL ra_write got %h want %h", RD1, 32'h0000ABCD); end
        total++; if (wcnt !== 32'd4) begin bad++; $display("FAIL ra_wcnt got %0d want 4", wcnt); end
        reset = 1'b1; WE = 1'b1; A3 = REG_RA; WD = 32'h00005555;
        step();
        reset = 1'b0; WE = 1'b0; A1 = REG_RA; A2 = 5'd8;
        #1;
        total++; if (nb_RD1 !== 32'h0) begin bad++; $display("FAIL rstprio_rd1 got %h want %h", nb_RD1, 32'h0); end
        total++; if (RD2 !== 32'h0) begin bad++; $display("FAIL rstprio_rd2 got %h want %h", RD2, 32'h0); end
        total++; if (wcnt !== 32'd0) begin bad++; $display("FAIL rstprio_wcnt got %0d want 0", wcnt); end
        total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL rstprio_tvalid got %b want 0", tvalid); end
        total++; if (tpc !== 32'h0) begin bad++; $display("FAIL rstprio_tpc got %h want %h", tpc, 32'h0); end
        // first edge after reset is a normal cycle
        WE = 1'b1; A3 = 5'd2; WD = 32'h77; PC = 32'h3014;
        step();
        WE = 1'b0; A1 = 5'd2;
        #1;
        total++; if (RD1 !== 32'h77) begin bad++; $display("FAIL post_rst_write got %h want %h", RD1, 32'h77); end
        total++; if (wcnt !== 32'd1) begin bad++; $display("FAIL post_rst_wcnt got %0d want 1", wcnt); end
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_sweep();
        logic [31:0] exp_v;
        for (int i = 1; i < 32; i++) begin
            WE = 1'b1; A3 = reg_addr_t'(i); WD = 32'(i * 3); PC = 32'h4000 + 32'(i * 4);
            step();
            total++; if (taddr !== reg_addr_t'(i)) begin bad++; $display("FAIL sweep_taddr got %0d want %0d", taddr, i); end
            total++; if (tdata !== 32'(i * 3)) begin bad++; $display("FAIL sweep_tdata got %0d want %0d", tdata, i * 3); end
            total++; if (tpc !== 32'h4000 + 32'(i * 4)) begin bad++; $display("FAIL sweep_tpc got %h want %h", tpc, 32'h4000 + 32'(i * 4)); end
            total++; if (wcnt !== 32'(i)) begin bad++; $display("FAIL sweep_wcnt got %0d want %0d", wcnt, i); end
        end
        WE = 1'b0;
        for (int i = 0; i < 32; i++) begin
            A1 = reg_addr_t'(i); A2 = reg_addr_t'(31 - i);
            #1;
            exp_v = 32'(i * 3);
            total++; if (RD1 !== exp_v) begin bad++; $display("FAIL sweep_rd1 r%0d got %0d want %0d", i, RD1, exp_v); end
            exp_v = 32'((31 - i) * 3);
            total++; if (RD2 !== exp_v) begin bad++; $display("FAIL sweep_rd2 r%0d got %0d want %0d", 31 - i, RD2, exp_v); end
        end
        step();
        total++; if (wcnt !== 32'd31) begin bad++; $display("FAIL sweep_final_wcnt got %0d want 31", wcnt); end
        total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL sweep_final_tvalid got %b want 0", tvalid); end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_zero_reg();
        test_bypass();
        test_reset_priority();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_grf
`default_nettype wire

// File: doc/grf.md
Name: grf

Overview:
- General register file for the single-cycle MIPS datapath.
- Sits directly downstream of the write-register select mux. That mux supplies the write address (rt, rd, or 31 for jal).
- Provides two asynchronous read ports to the ALU/compare logic and one synchronous write port.
- Keeps a registered write-trace record used by the course-style $display checker and the testbench scoreboard.

Parameters:
- NUM_REGS, 32, number of architectural registers; address width is log2(NUM_REGS) = 5.
- DATA_W, 32, register width in bits.
- BYPASS, 1, when 1 a read of the address being written this cycle returns WD (write-through); when 0 it returns the stored value.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- WE  input  1  write enable from the control unit.
- A1  input  5  read address 1 (rs).
- A2  input  5  read address 2 (rt).
- A3  input  5  write address (output of the write-register select mux).
- WD  input  32  write data.
- PC  input  32  PC of the instruction currently writing; used for trace only.
- RD1  output  32  read data 1, combinational.
- RD2  output  32  read data 2, combinational.
- trace_valid  output  1  a non-$0 write committed on the last edge.
- trace_pc  output  32  PC of the last committed write.
- trace_addr  output  5  register number of the last committed write.
- trace_data  output  32  value of the last committed write.
- write_count  output  32  count of committed non-$0 writes since reset.

Behaviour:
- Reset (sampled at posedge clk with reset=1):
  - All registers are cleared to 0.
  - trace_valid, trace_pc, trace_addr, trace_data and write_count are all set to 0.
  - reset takes priority over WE in the same cycle; no write commits.
- Write:
  - At posedge clk with reset=0, WE=1 and A3!=0, reg[A3] <= WD. Write latency is 1 cycle.
  - A3 == 0 never writes. reg[0] reads 0 at all times, including under BYPASS.
- Read:
  - RD1 = (A1==0) ? 0 : (BYPASS && WE && A3==A1) ? WD : reg[A1]. RD2 is formed the same way with A2.
  - Reads are purely combinational, with zero latency.
- Trace:
  - On each committed write (WE=1, A3!=0, reset=0), in the same edge: trace_valid<=1, trace_pc<=PC, trace_addr<=A3, trace_data<=WD, write_count<=write_count+1.
  - On any other non-reset edge, trace_valid<=0 and the other trace fields hold their values.
  - write_count wraps from 0xFFFFFFFF to 0 with no saturation.
- Simultaneous events:
  - A1==A2==A3 with WE=1 and BYPASS=1: both read ports return WD.
  - A write to 31 (jal link) behaves as any other register.
- Reset mid-program: the next edge after reset deasserts is a normal cycle. A write presented in the same cycle as reset is discarded.
- X handling: WE=X is not legal. The bench must drive WE to a known value whenever reset=0.

Decomposition:
- Shared package mips_defs:
  - REG_ZERO = 5'd0 and REG_RA = 5'd31.
  - NUM_REGS and DATA_W defaults.
  - A reg_addr_t 5-bit typedef, also usable by the write-register select mux and the control unit.
- One sub-module, grf_read_port, instantiated twice.
  - Inputs: addr, storage array view, WE, A3, WD.
  - Output: the read value.
  - Implements the $0 forcing and the BYPASS compare.
- The storage array, write logic and trace registers stay in grf.

Test Plan:
- Reset then read: assert reset 1 cycle, then A1=5, A2=31 -> RD1=0, RD2=0, write_count=0, trace_valid=0.
- Basic write/read: WE=1, A3=8, WD=0x12345678, PC=0x3000 for 1 cycle, then WE=0, A1=8 -> RD1=0x12345678; trace_valid=1 for 1 cycle with trace_pc=0x3000, trace_addr=8; write_count=1.
- $0 protection: WE=1, A3=0, WD=0xFFFFFFFF -> A1=0 gives RD1=0; trace_valid=0; write_count unchanged.
- Bypass: BYPASS=1, WE=1, A3=A1=A2=9, WD=0xDEADBEEF with reg[9]=0x1 -> RD1=RD2=0xDEADBEEF in the same cycle. Repeat with BYPASS=0 -> RD1=RD2=0x1 until the edge, then 0xDEADBEEF.
- Reset priority: reg[31]=0xABCD, then reset=1 with WE=1, A3=31, WD=0x5555 -> after the edge, reg[31]=0 and write_count=0.
- Sweep: write WD=i*3 to registers 1..31 on consecutive cycles -> each readback matches, reg[0]=0, write_count=31, and trace_addr follows 1..31.
